// File: rtl/bridge_engine_pkg.sv
// Shared types for the AXI2APB bridge sequencer: engine states, grant side and
// the cmd/info bundles exchanged with the axi_reader, axi_writer and APB master.
package bridge_utils;

  localparam int BRIDGE_LEN_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_BEAT  = 2'd2,
    ST_RESP  = 2'd3
  } engine_state_t;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_t;

  typedef struct packed {
    logic start;
    logic resp;
  } wr_cmd_t;

  typedef struct packed {
    logic start;
    logic resp;
  } rd_cmd_t;

  typedef struct packed {
    logic start;
    logic write;
  } apb_cmd_t;

  typedef struct packed {
    logic req;
    logic fifo_empty;
  } wr_info_t;

  typedef struct packed {
    logic req;
    logic fifo_full;
  } rd_info_t;

  typedef struct packed {
    logic done;
    logic err;
  } apb_info_t;

endpackage

// File: rtl/bridge_rr_arbiter.sv
// Two-requester round-robin arbiter: on a tie the side that was not served
// last wins; last_grant moves only when the engine strobes burst completion.
module bridge_rr_arbiter
  import bridge_utils::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_req_i,
  input  logic   rd_req_i,
  input  logic   update_i,
  input  grant_t update_grant_i,
  output logic   grant_valid_o,
  output grant_t grant_o
);

  grant_t last_grant_q, last_grant_d;

  always_comb begin
    grant_valid_o = wr_req_i | rd_req_i;
    grant_o       = GRANT_RD;
    if (wr_req_i && rd_req_i) begin
      grant_o = (last_grant_q == GRANT_WR) ? GRANT_RD : GRANT_WR;
    end else if (wr_req_i) begin
      grant_o = GRANT_WR;
    end
    last_grant_d = update_i ? update_grant_i : last_grant_q;
  end

  // Reset to READ so that a write wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_RD;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/bridge_engine.sv
// AXI2APB bridge sequencer: arbitrates write/read bursts, issues one APB beat at
// a time gated on FIFO status, and reports completion. Option: BRIDGE_TIMEOUT_EN.
module bridge_engine
  import bridge_utils::*;
#(
  parameter int LEN_WIDTH      = BRIDGE_LEN_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_req_i,
  input  logic [LEN_WIDTH-1:0] wr_len_i,
  output logic                 wr_start_o,
  output logic                 wr_resp_o,
  input  logic                 wr_fifo_empty_i,
  input  logic                 rd_req_i,
  input  logic [LEN_WIDTH-1:0] rd_len_i,
  output logic                 rd_start_o,
  output logic                 rd_resp_o,
  input  logic                 rd_fifo_full_i,
  output logic                 resp_err_o,
  output logic                 apb_start_o,
  output logic                 apb_write_o,
  input  logic                 apb_done_i,
  input  logic                 apb_err_i,
  output logic [LEN_WIDTH-1:0] beat_idx_o,
  output logic                 busy_o
);

  engine_state_t        state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [LEN_WIDTH-1:0] idx_q, idx_d;
  logic                 write_q, write_d;
  logic                 err_q, err_d;

  wr_info_t  wr_info;
  rd_info_t  rd_info;
  apb_info_t apb_info;
  wr_cmd_t   wr_cmd;
  rd_cmd_t   rd_cmd;
  apb_cmd_t  apb_cmd;

  logic   grant_valid;
  grant_t grant;
  grant_t cur_side;
  logic   arb_update;
  logic   resp_err;
  logic   beat_done;
  logic   beat_err;

  assign wr_info  = '{req: wr_req_i, fifo_empty: wr_fifo_empty_i};
  assign rd_info  = '{req: rd_req_i, fifo_full: rd_fifo_full_i};
  assign apb_info = '{done: apb_done_i, err: apb_err_i};
  assign cur_side = write_q ? GRANT_WR : GRANT_RD;

  bridge_rr_arbiter u_arb (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_req_i       (wr_info.req),
    .rd_req_i       (rd_info.req),
    .update_i       (arb_update),
    .update_grant_i (cur_side),
    .grant_valid_o  (grant_valid),
    .grant_o        (grant)
  );

`ifdef BRIDGE_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              wdog_expired;

  // A stuck beat is closed as if the slave answered with PSLVERR.
  assign wdog_expired = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign beat_done    = apb_info.done | wdog_expired;
  assign beat_err     = apb_info.done ? apb_info.err : 1'b1;
  assign wdog_d       = ((state_q == ST_BEAT) && !beat_done) ? wdog_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign beat_done      = apb_info.done;
  assign beat_err       = apb_info.err;
`endif

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    idx_d         = idx_q;
    write_d       = write_q;
    err_d         = err_q;
    wr_cmd        = '0;
    rd_cmd        = '0;
    apb_cmd       = '0;
    apb_cmd.write = write_q;
    arb_update    = 1'b0;
    resp_err      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          wr_cmd.start = (grant == GRANT_WR);
          rd_cmd.start = (grant == GRANT_RD);
          rem_d        = (grant == GRANT_WR) ? wr_len_i : rd_len_i;
          idx_d        = '0;
          write_d      = (grant == GRANT_WR);
          state_d      = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (write_q ? !wr_info.fifo_empty : !rd_info.fifo_full) begin
          apb_cmd.start = 1'b1;
          state_d       = ST_BEAT;
        end
      end
      ST_BEAT: begin
        if (beat_done) begin
          err_d = err_q | beat_err;
          if (rem_q == '0) begin
            state_d = ST_RESP;
          end else begin
            rem_d   = rem_q - 1'b1;
            idx_d   = idx_q + 1'b1;
            state_d = ST_CHECK;
          end
        end
      end
      ST_RESP: begin
        wr_cmd.resp = write_q;
        rd_cmd.resp = !write_q;
        resp_err    = err_q;
        err_d       = 1'b0;
        arb_update  = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  // Start pulses are combinational from the requests, so hold them low in reset.
  assign wr_start_o  = wr_cmd.start & rst_n;
  assign rd_start_o  = rd_cmd.start & rst_n;
  assign wr_resp_o   = wr_cmd.resp;
  assign rd_resp_o   = rd_cmd.resp;
  assign resp_err_o  = resp_err;
  assign apb_start_o = apb_cmd.start;
  assign apb_write_o = apb_cmd.write;
  assign beat_idx_o  = idx_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
